// File: rtl/adder_serial_n_bit.sv
// Digit-serial adder/subtractor: DIGIT bits per clock over WIDTH-bit operands.
// start/busy/done handshake; S/C/V held until the next operation completes.
module adder_serial_n_bit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   sum;
  logic             carry;
  logic             xa;
  logic             yb;
  logic             last;
  logic             load;

  assign last = (cnt == CW'(N - 1));
  assign load = start && (state != RUN);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  assign sum = {1'b0, a[DIGIT-1:0]}
             + {1'b0, b[DIGIT-1:0]}
             + (DIGIT+1)'(carry);

  // New digit enters at the top; after N beats the LSB digit sits at bit 0.
  assign res_nxt = (res >> DIGIT)
                 | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      res   <= '0;
      carry <= 1'b0;
      xa    <= 1'b0;
      yb    <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
    end else if (load) begin
      // Subtract as X + ~Y + ~cin.
      a     <= X;
      b     <= Y ^ {WIDTH{sub}};
      carry <= cin ^ sub;
      xa    <= X[WIDTH-1];
      yb    <= Y[WIDTH-1] ^ sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a     <= a >> DIGIT;
      b     <= b >> DIGIT;
      res   <= res_nxt;
      carry <= sum[DIGIT];
      cnt   <= cnt + CW'(1);
      if (last) begin
        S <= res_nxt;
        C <= sum[DIGIT];
        V <= (xa == yb) && (res_nxt[WIDTH-1] != xa);
      end
    end
  end

endmodule

// File: tb/tb_adder_serial_n_bit.sv
// Scoreboard bench for adder_serial_n_bit in three configurations:
// ch0 = 8/2, ch1 = 16/16, ch2 = 16/1.
module tb_adder_serial_n_bit;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_q = 1'b1;
  logic [2:0]  start = '0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] X = '0;
  logic [15:0] Y = '0;

  logic [7:0]  s8;
  logic [15:0] s16a;
  logic [15:0] s16b;
  logic [15:0] s_w [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic        c_w [3];
  logic        v_w [3];

  exp_t        sb [3][$];
  logic [15:0] last_s [3];
  logic        last_c [3];
  logic        last_v [3];
  int          busy_run [3];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          last_due = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  adder_serial_n_bit #(.WIDTH(8), .DIGIT(2)) u_8_2 (
    .clk(clk), .rst(rst), .start(start[0]), .sub(sub), .cin(cin),
    .X(X[7:0]), .Y(Y[7:0]), .busy(busy_w[0]), .done(done_w[0]),
    .S(s8), .C(c_w[0]), .V(v_w[0])
  );

  adder_serial_n_bit #(.WIDTH(16), .DIGIT(16)) u_16_16 (
    .clk(clk), .rst(rst), .start(start[1]), .sub(sub), .cin(cin),
    .X(X), .Y(Y), .busy(busy_w[1]), .done(done_w[1]),
    .S(s16a), .C(c_w[1]), .V(v_w[1])
  );

  adder_serial_n_bit #(.WIDTH(16), .DIGIT(1)) u_16_1 (
    .clk(clk), .rst(rst), .start(start[2]), .sub(sub), .cin(cin),
    .X(X), .Y(Y), .busy(busy_w[2]), .done(done_w[2]),
    .S(s16b), .C(c_w[2]), .V(v_w[2])
  );

  assign s_w[0] = {8'h00, s8};
  assign s_w[1] = s16a;
  assign s_w[2] = s16b;

  function automatic int nb(int ch);
    case (ch)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  // Monitor: pops on every done, checks hold of S/C/V otherwise.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst_q) begin
        last_s[i]   = s_w[i];
        last_c[i]   = c_w[i];
        last_v[i]   = v_w[i];
        busy_run[i] = 0;
      end else if (done_w[i]) begin
        n_chk++;
        if (sb[i].size() == 0) begin
          n_fail++;
          $display("FAIL ch%0d unexpected_done cyc=%0d S=%h", i, cyc, s_w[i]);
        end else begin
          e = sb[i].pop_front();
          if (s_w[i] !== e.s || c_w[i] !== e.c || v_w[i] !== e.v ||
              cyc != e.due || busy_run[i] != nb(i) || busy_w[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL ch%0d result got S=%h C=%b V=%b cyc=%0d busy_cyc=%0d busy=%b want S=%h C=%b V=%b cyc=%0d busy_cyc=%0d busy=0",
                     i, s_w[i], c_w[i], v_w[i], cyc, busy_run[i], busy_w[i],
                     e.s, e.c, e.v, e.due, nb(i));
          end
        end
        last_s[i]   = s_w[i];
        last_c[i]   = c_w[i];
        last_v[i]   = v_w[i];
        busy_run[i] = 0;
      end else begin
        busy_run[i] = busy_w[i] ? busy_run[i] + 1 : 0;
        n_chk++;
        if (s_w[i] !== last_s[i] || c_w[i] !== last_c[i] || v_w[i] !== last_v[i]) begin
          n_fail++;
          $display("FAIL ch%0d hold got S=%h C=%b V=%b want S=%h C=%b V=%b cyc=%0d",
                   i, s_w[i], c_w[i], v_w[i], last_s[i], last_c[i], last_v[i], cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int ch, input logic [15:0] x, input logic [15:0] y,
                       input logic sb_i, input logic ci, input logic [15:0] es,
                       input logic ec, input logic ev);
    exp_t e;
    X         = x;
    Y         = y;
    sub       = sb_i;
    cin       = ci;
    start[ch] = 1'b1;
    e.s = es;
    e.c = ec;
    e.v = ev;
    e.due = cyc + 1 + nb(ch);
    last_due = e.due;
    sb[ch].push_back(e);
    tick();
    start[ch] = 1'b0;
  endtask

  task automatic drain(input int ch);
    int n;
    n = 0;
    while (sb[ch].size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (sb[ch].size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL ch%0d timeout pending=%0d want 0", ch, sb[ch].size());
      sb[ch].delete();
    end
    tick();
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || s_w[i] !== 16'h0 ||
          c_w[i] !== 1'b0 || v_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL ch%0d %s got busy=%b done=%b S=%h C=%b V=%b want all 0",
                 i, name, busy_w[i], done_w[i], s_w[i], c_w[i], v_w[i]);
      end
    end
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset_state");
    tick();

    issue(0, 16'd200, 16'd100, 1'b0, 1'b0, 16'd44, 1'b1, 1'b0);
    drain(0);
    issue(0, 16'd127, 16'd1, 1'b0, 1'b0, 16'd128, 1'b0, 1'b1);
    drain(0);
    issue(0, 16'd255, 16'd0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0);
    drain(0);
    issue(0, 16'd5, 16'd7, 1'b1, 1'b0, 16'd254, 1'b0, 1'b0);
    drain(0);
    issue(0, 16'd128, 16'd1, 1'b1, 1'b0, 16'd127, 1'b1, 1'b1);
    drain(0);
    issue(0, 16'd10, 16'd3, 1'b1, 1'b1, 16'd6, 1'b1, 1'b0);
    drain(0);

    // start pulsed mid-RUN with other operands must be ignored
    issue(0, 16'd3, 16'd4, 1'b0, 1'b0, 16'd7, 1'b0, 1'b0);
    tick();
    X        = 16'd100;
    Y        = 16'd100;
    sub      = 1'b1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    drain(0);

    // back-to-back: second start held during the DONE cycle
    issue(0, 16'd50, 16'd60, 1'b0, 1'b0, 16'd110, 1'b0, 1'b0);
    while (cyc < last_due) tick();
    issue(0, 16'd100, 16'd100, 1'b0, 1'b0, 16'd200, 1'b0, 1'b1);
    drain(0);

    // reset mid-operation discards it; no done may follow
    issue(0, 16'd200, 16'd100, 1'b0, 1'b0, 16'd44, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb[0].delete();
    check_idle("mid_reset");
    repeat (10) tick();

    issue(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain(1);
    issue(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain(2);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_serial_n_bit.md
Name: adder_serial_n_bit

Overview:
Parametrised multi-cycle adder/subtractor, successor to the fixed 2-bit combinational adder. Adds (or subtracts) two WIDTH-bit operands DIGIT bits per clock, using a start/busy/done handshake. Provides sum, carry-out and signed overflow. Used wherever wide operands must share one narrow adder slice (lab datapaths, ALU experiments).

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥ 2.
DIGIT, 2, bits processed per cycle; WIDTH % DIGIT must be 0; 1 ≤ DIGIT ≤ WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request a new operation; sampled only in IDLE or DONE
sub  input  1  0: S = X + Y + cin; 1: S = X - Y - cin (cin acts as borrow-in)
cin  input  1  carry-in (add) / borrow-in (sub)
X  input  WIDTH  operand A, sampled with start
Y  input  WIDTH  operand B, sampled with start
busy  output  1  high while an operation is in RUN
done  output  1  one-cycle pulse: S/C/V valid and newly updated
S  output  WIDTH  result, held until the next operation completes
C  output  1  final carry-out (sub: 1 = no borrow, 0 = borrow)
V  output  1  signed (two's complement) overflow

Behaviour:
- Reset: state=IDLE; busy=0, done=0, S=0, C=0, V=0; internal shift registers and carry cleared. rst overrides every other input, including mid-operation; any in-flight operation is discarded.
- N = WIDTH/DIGIT beats per operation.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. If start=1: latch A=X, B=Y^{WIDTH{sub}}, carry=cin^sub, MSB signs xa=X[WIDTH-1], yb=B[WIDTH-1]; beat counter=0; go to RUN.
  - RUN: busy=1. Each cycle: {carry, d} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry; shift A and B right by DIGIT; shift d into the result register from the top. Counter increments. start is ignored. On beat N-1, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. S, C and V are updated on the edge entering DONE. C=final carry. V=(xa==yb) & (S[WIDTH-1]!=xa). If start=1, latch new operands as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- Latency: start sampled at edge k, busy=1 during cycles k+1..k+N, done=1 during cycle k+N+1. Throughput is one operation per N+1 cycles.
- S/C/V change only on the edge into DONE or on reset. They stay stable during RUN, so the previous result remains readable.
- Arithmetic is modulo 2^WIDTH. Subtraction computes X + ~Y + ~cin.
- DIGIT=WIDTH degenerates to N=1: one RUN cycle, then DONE.
- X, Y, sub and cin are don't-care except in the start-sampling cycle.

Test Plan:
- WIDTH=8, DIGIT=2, add X=200, Y=100, cin=0 -> S=44, C=1, V=0. busy high 4 cycles, done in cycle k+5 only.
- Add X=127, Y=1, cin=0 -> S=128, C=0, V=1. Add X=255, Y=0, cin=1 -> S=0, C=1, V=0.
- sub=1, X=5, Y=7, cin=0 -> S=254, C=0, V=0. sub=1, X=128, Y=1, cin=0 -> S=127, C=1, V=1. sub=1, X=10, Y=3, cin=1 -> S=6, C=1.
- Pulse start again during RUN with different operands -> ignored; first result delivered unchanged. Hold start high in the DONE cycle -> next operation begins with no IDLE cycle, and its done arrives 5 cycles later.
- Assert rst during beat 2 of an operation -> next cycle busy=0, done=0, S=0, C=0, V=0, state IDLE. No done pulse follows.
- Re-run with WIDTH=16, DIGIT=16 and WIDTH=16, DIGIT=1: 0xFFFF+0x0001 -> S=0, C=1, V=0. done arrives at k+2 and k+17 respectively.
